// File: rtl/fetch_flow_ctrl_if.sv
// Fetch flow-control bundle: hazard requests, redirect targets, imem read data
// in; PC, IF/ID register, ID/EX bubble and event counters out.
interface fetch_flow_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      imem_instr;
  logic             load_use_hazard_stall;
  logic             branch_hazard_flush;
  logic             jump_flush;
  logic [31:0]      branch_target;
  logic [31:0]      jump_target;
  logic [31:0]      jr_target;
  logic             is_jr;
  logic [31:0]      pc;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Hazard unit / pipeline side
  modport master (
    output imem_instr, load_use_hazard_stall, branch_hazard_flush, jump_flush,
           branch_target, jump_target, jr_target, is_jr,
    input  pc, if_id_instr, if_id_pc4, if_id_valid, id_ex_bubble, stall_cnt, flush_cnt
  );

  // Fetch flow controller side
  modport slave (
    input  imem_instr, load_use_hazard_stall, branch_hazard_flush, jump_flush,
           branch_target, jump_target, jr_target, is_jr,
    output pc, if_id_instr, if_id_pc4, if_id_valid, id_ex_bubble, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_flow_ctrl.sv
// Fetch flow controller: owns PC and IF/ID, applies one stall/flush event per
// cycle, and keeps saturating stall/flush event counters.
module fetch_flow_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst_n,
  fetch_flow_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {EvNormal, EvBranch, EvStall, EvJump} event_e;

  event_e           ev;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      if_id_instr_q, if_id_instr_d;
  logic [31:0]      if_id_pc4_q, if_id_pc4_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]      pc4;

  assign pc4 = pc_q + 32'd4;

  // Pick the single event for this edge; a branch squashes a stalled wrong-path
  // ID instruction, and a jump waits out a stall until its operand is ready.
  always_comb begin
    ev = EvNormal;
    if (bus.branch_hazard_flush) begin
      ev = EvBranch;
    end else if (bus.load_use_hazard_stall) begin
      ev = EvStall;
    end else if (bus.jump_flush) begin
      ev = EvJump;
    end
  end

  // Next-state for PC, IF/ID and counters.
  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    unique case (ev)
      EvBranch, EvJump: begin
        pc_d          = (ev == EvBranch) ? bus.branch_target :
                        (bus.is_jr ? bus.jr_target : bus.jump_target);
        if_id_instr_d = NOP_INSTR;
        if_id_pc4_d   = 32'd0;
        if_id_valid_d = 1'b0;
        if (flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      EvStall: begin
        if (stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      default: begin
        pc_d          = pc4;
        if_id_instr_d = bus.imem_instr;
        if_id_pc4_d   = pc4;
        if_id_valid_d = 1'b1;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.if_id_instr  = if_id_instr_q;
  assign bus.if_id_pc4    = if_id_pc4_q;
  assign bus.if_id_valid  = if_id_valid_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
  // Zero-latency bubble; a jump alone must reach EX to write its link register.
  assign bus.id_ex_bubble = bus.branch_hazard_flush | bus.load_use_hazard_stall;

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Scoreboard bench for fetch_flow_ctrl: a reference model pushes expected
// post-edge state per cycle, each scenario task pops and compares.
module tb_fetch_flow_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic        bub;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fetch_flow_ctrl_if #(.CNT_W(16)) bus ();
  fetch_flow_ctrl_if #(.CNT_W(2))  b2 ();

  fetch_flow_ctrl #(.RESET_PC(32'h0), .CNT_W(16), .NOP_INSTR(NOP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  fetch_flow_ctrl #(.RESET_PC(32'h0), .CNT_W(2), .NOP_INSTR(NOP)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b2.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_instr = imem_of(bus.pc);
  assign b2.imem_instr  = 32'hDEAD_BEEF;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [15:0] m_sc, m_fc;
  obs_t        sb[$];
  logic [1:0]  sb2[$];
  logic        obs_bub;
  obs_t        obs;

  function automatic obs_t sample(input logic bub);
    obs_t o;
    o.bub = bub; o.pc = bus.pc; o.instr = bus.if_id_instr; o.pc4 = bus.if_id_pc4;
    o.valid = bus.if_id_valid; o.sc = bus.stall_cnt; o.fc = bus.flush_cnt;
    return o;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0; m_sc = '0; m_fc = '0;
  endtask

  task automatic set_in(input logic br, st, jf, jr, input logic [31:0] bt, jt, jrt);
    bus.branch_hazard_flush   = br;
    bus.load_use_hazard_stall = st;
    bus.jump_flush            = jf;
    bus.is_jr                 = jr;
    bus.branch_target         = bt;
    bus.jump_target           = jt;
    bus.jr_target             = jrt;
  endtask

  // Drive one cycle, model it, push expectation, advance past the edge.
  task automatic step(input logic br, st, jf, jr, input logic [31:0] bt, jt, jrt);
    obs_t e;
    set_in(br, st, jf, jr, bt, jt, jrt);
    #1;
    obs_bub = bus.id_ex_bubble;
    e.bub = br | st;
    if (br) begin
      m_pc = bt; m_instr = NOP; m_pc4 = 0; m_valid = 0;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 1;
    end else if (st) begin
      if (m_sc != 16'hFFFF) m_sc = m_sc + 1;
    end else if (jf) begin
      m_pc = jr ? jrt : jt; m_instr = NOP; m_pc4 = 0; m_valid = 0;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 1;
    end else begin
      m_instr = imem_of(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs = sample(obs_bub);
  endtask

  task automatic test_reset();
    obs_t e;
    set_in(0, 0, 0, 0, 0, 0, 0);
    b2.load_use_hazard_stall = 0; b2.branch_hazard_flush = 0; b2.jump_flush = 0;
    b2.is_jr = 0; b2.branch_target = 0; b2.jump_target = 0; b2.jr_target = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    e = '{bub: 1'b0, pc: 32'h0, instr: NOP, pc4: 32'h0, valid: 1'b0, sc: 16'h0, fc: 16'h0};
    obs = sample(bus.id_ex_bubble);
    total++;
    if (obs !== e) begin bad++; $display("FAIL reset: got %h want %h", obs, e); end
    total++;
    if (b2.stall_cnt !== 2'd0) begin
      bad++; $display("FAIL reset_cnt2: got %0d want 0", b2.stall_cnt);
    end
    #6 rst_n = 1'b1;
  endtask

  task automatic test_normal();
    obs_t e;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL normal%0d: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_stall();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      step(0, (i < 2), 0, 0, 0, 0, 0);
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL stall%0d: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_jump();
    obs_t e;
    step(0, 0, 1, 0, 32'h0, 32'h100, 32'h9999_0000);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL jump: got %h want %h", obs, e); end
    step(0, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL jump_next: got %h want %h", obs, e); end
  endtask

  task automatic test_branch_stall();
    obs_t e;
    step(1, 1, 0, 0, 32'h40, 32'h200, 32'h300);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL branch_stall: got %h want %h", obs, e); end
  endtask

  task automatic test_stall_jump();
    obs_t e;
    step(0, 1, 1, 1, 32'h0, 32'h500, 32'h80);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL stall_jump1: got %h want %h", obs, e); end
    step(0, 0, 1, 1, 32'h0, 32'h500, 32'h80);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL stall_jump2: got %h want %h", obs, e); end
  endtask

  task automatic test_wrap();
    obs_t e;
    step(1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL wrap_br: got %h want %h", obs, e); end
    step(0, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL wrap: got %h want %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    step(0, 0, 1, 0, 32'h0, 32'h0000_0600, 32'h0000_0700);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL b2b_jump: got %h want %h", obs, e); end
    step(1, 0, 0, 0, 32'h0000_0A00, 32'h0, 32'h0);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL b2b_branch: got %h want %h", obs, e); end
    step(0, 0, 1, 1, 32'h0, 32'h0000_0600, 32'h0000_0704);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL b2b_jr: got %h want %h", obs, e); end
  endtask

  task automatic test_saturation();
    obs_t       e;
    logic [1:0] e2;
    for (int i = 0; i < 5; i++) begin
      b2.load_use_hazard_stall = 1'b1;
      sb2.push_back((i < 3) ? 2'(i + 1) : 2'd3);
      step(0, 0, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      e2 = sb2.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL sat_main%0d: got %h want %h", i, obs, e); end
      total++;
      if (b2.stall_cnt !== e2) begin
        bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, b2.stall_cnt, e2);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    obs_t e;
    step(0, 1, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL pre_rst: got %h want %h", obs, e); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    obs = sample(bus.id_ex_bubble);
    e = '{bub: 1'b1, pc: 32'h0, instr: NOP, pc4: 32'h0, valid: 1'b0, sc: 16'h0, fc: 16'h0};
    total++;
    if (obs !== e) begin bad++; $display("FAIL rst_mid: got %h want %h", obs, e); end
    total++;
    if (b2.stall_cnt !== 2'd0 || b2.pc !== 32'h0) begin
      bad++; $display("FAIL rst_mid2: got cnt=%0d pc=%h want 0/0", b2.stall_cnt, b2.pc);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    b2.load_use_hazard_stall = 1'b0;
    #2 rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    total++;
    if (obs !== e) begin bad++; $display("FAIL post_rst: got %h want %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stall();
    test_jump();
    test_branch_stall();
    test_stall_jump();
    test_wrap();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
